// File: rtl/i2c_txn_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter_if
//   Bundles the client-side request/grant signals and the I2C master's
//   parallel interface that the transaction arbiter sits between.
//
//   Handshake:
//     - A client raises req[i] with req_rw/req_addr/req_wdata and holds it
//       until its done[i] pulse.
//     - The arbiter answers with a one-hot gnt that stays set from the cycle
//       after the request is sampled until the cycle after done.
//     - done is a one-cycle pulse; rdata/nack/tmo are valid from that cycle
//       until the next completion.
//     - Toward the master, m_start is a one-cycle pulse with m_rw/m_addr/
//       m_wdata stable.
//     - The master answers with a one-cycle m_done; m_rdata and m_ack_err
//       are qualified by m_done.
//
//   Modports:
//     master - the arbiter: drives gnt/done/rdata/nack/tmo/m_start/m_rw/m_addr/m_wdata
//     slave  - the environment (clients and I2C master): drives the rest
// ---------------------------------------------------------------------------
interface i2c_txn_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   nack;
    logic                   tmo;
    logic                   m_start;
    logic                   m_rw;
    logic [ADDR_W-1:0]      m_addr;
    logic [DATA_W-1:0]      m_wdata;
    logic                   m_busy;
    logic                   m_done;
    logic [DATA_W-1:0]      m_rdata;
    logic                   m_ack_err;

    modport master (
        input  req, req_rw, req_addr, req_wdata,
        input  m_busy, m_done, m_rdata, m_ack_err,
        output gnt, done, rdata, nack, tmo,
        output m_start, m_rw, m_addr, m_wdata
    );

    modport slave (
        output req, req_rw, req_addr, req_wdata,
        output m_busy, m_done, m_rdata, m_ack_err,
        input  gnt, done, rdata, nack, tmo,
        input  m_start, m_rw, m_addr, m_wdata
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter
//   Shares one I2C master between NREQ clients. Grants round-robin, latches
//   the winner's rw/address/write byte, pulses the master's start, waits for
//   its completion and returns read byte and ack status with a done pulse.
//
//   Ports:
//     clk          clock
//     rst          synchronous, active-low reset
//     bus          i2c_txn_arbiter_if.master (client and master-side signals)
//     dbg_state_o  current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
//   Optional feature (macro I2C_ARB_TIMEOUT_EN):
//     Adds parameter TIMEOUT and a WAIT-state counter; after TIMEOUT WAIT
//     cycles without m_done the transaction completes with nack=1, tmo=1.
//     Without the macro no counter exists, WAIT waits forever, tmo is 0.
// ---------------------------------------------------------------------------
module i2c_txn_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
`ifdef I2C_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  logic              clk,
    input  logic              rst,
    i2c_txn_arbiter_if.master bus,
    output logic [1:0]        dbg_state_o
);
    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    win_q;
    logic [NREQ-1:0]     gnt_q;
    logic [NREQ-1:0]     done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                nack_q;
    logic                m_start_q;
    logic                m_rw_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;

    logic [PTR_W-1:0]    win_d;
    logic [NREQ-1:0]     gnt_d;
    logic                found;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q;
    logic                tmo_q;
`endif

    // Round-robin pick: first set request scanning upward from ptr_q+1,
    // wrapping at NREQ. ptr_q holds the last winner, so it gets lowest
    // priority on the next pick.
    always_comb begin
        found = 1'b0;
        win_d = '0;
        gnt_d = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win_d = PTR_W'(idx);
            end
        end
        gnt_d[win_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(NREQ - 1);
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            m_start_q <= 1'b0;
            m_rw_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (found && !bus.m_busy) begin
                        win_q     <= win_d;
                        gnt_q     <= gnt_d;
                        m_rw_q    <= bus.req_rw[win_d];
                        m_addr_q  <= bus.req_addr[win_d*ADDR_W +: ADDR_W];
                        m_wdata_q <= bus.req_wdata[win_d*DATA_W +: DATA_W];
                        m_start_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start_q <= 1'b0;
                    state_q   <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                end
                WAIT: begin
                    if (bus.m_done) begin
                        // Writes leave the last read byte in place.
                        if (m_rw_q) begin
                            rdata_q <= bus.m_rdata;
                        end
                        nack_q  <= bus.m_ack_err;
                        done_q  <= gnt_q;
                        state_q <= RESP;
`ifdef I2C_ARB_TIMEOUT_EN
                        tmo_q   <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // TIMEOUT WAIT cycles elapsed with no completion.
                        nack_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        done_q  <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    ptr_q   <= win_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.nack    = nack_q;
    assign bus.m_start = m_start_q;
    assign bus.m_rw    = m_rw_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign bus.tmo     = tmo_q;
`else
    assign bus.tmo     = 1'b0;
`endif
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  i2c_txn_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
`ifdef I2C_ARB_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rr_last;                    // last winner per the round-robin rule
  logic [DATA_W-1:0] exp_rdata;   // last read byte delivered
  logic exp_nack;
  logic [31:0] exp_q[$];          // expected grant order under contention

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Next owner: first requester after the last winner, wrapping around.
  function automatic int pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.req[i] = 1'b1;
    bus.req_rw[i] = rw;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Runs one arbitrated transaction from an idle arbiter with requests
  // already driven; the master model answers after 'hold' extra WAIT cycles.
  task automatic do_txn(input int hold, input logic [DATA_W-1:0] rd, input logic ack_err,
                        input bit drop, output int won);
    int w;
    int waited;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic erw;
    w = pick(rr_last, bus.req);
    won = w;
    if (w < 0) return;
    ea  = bus.req_addr[w*ADDR_W +: ADDR_W];
    ed  = bus.req_wdata[w*DATA_W +: DATA_W];
    erw = bus.req_rw[w];
    waited = 0;
    do begin
      tick();
      waited++;
    end while (bus.gnt == '0 && waited < 20);
    check("gnt", bus.gnt, onehot(w));
    check("gnt_latency", waited, 1);
    if (bus.gnt == '0) return;
    check("m_start", bus.m_start, 1);
    check("m_addr", bus.m_addr, ea);
    check("m_wdata", bus.m_wdata, ed);
    check("m_rw", bus.m_rw, erw);
    // Client-side changes after grant must not reach the master.
    bus.req_addr[w*ADDR_W +: ADDR_W] = ~ea;
    bus.req_wdata[w*DATA_W +: DATA_W] = ~ed;
    bus.req_rw[w] = ~erw;
    if (drop) bus.req[w] = 1'b0;
    bus.m_busy = 1'b1;
    tick();
    check("m_start_single", bus.m_start, 0);
    check("gnt_hold", bus.gnt, onehot(w));
    check("m_addr_hold", bus.m_addr, ea);
    for (int c = 0; c < hold; c++) begin
      tick();
      check("done_early", bus.done, 0);
    end
    bus.m_done = 1'b1;
    bus.m_rdata = rd;
    bus.m_ack_err = ack_err;
    tick();
    bus.m_done = 1'b0;
    bus.m_busy = 1'b0;
    bus.m_rdata = DATA_W'($urandom);
    bus.m_ack_err = 1'($urandom);
    if (erw) exp_rdata = rd;
    exp_nack = ack_err;
    check("done", bus.done, onehot(w));
    check("rdata", bus.rdata, exp_rdata);
    check("nack", bus.nack, exp_nack);
    check("tmo", bus.tmo, 0);
    check("gnt_at_done", bus.gnt, onehot(w));
    tick();
    check("done_single", bus.done, 0);
    check("gnt_release", bus.gnt, 0);
    rr_last = w;
  endtask

  task automatic clear_inputs();
    bus.req = '0;
    bus.req_rw = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.m_busy = 1'b0;
    bus.m_done = 1'b0;
    bus.m_rdata = '0;
    bus.m_ack_err = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, bus.gnt, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_nack"}, bus.nack, 0);
    check({tag, "_tmo"}, bus.tmo, 0);
    check({tag, "_m_start"}, bus.m_start, 0);
    check({tag, "_m_rw"}, bus.m_rw, 0);
    check({tag, "_m_addr"}, bus.m_addr, 0);
    check({tag, "_m_wdata"}, bus.m_wdata, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [NREQ-1:0] pending;

    clear_inputs();
    rst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    rr_last = NREQ - 1;
    exp_rdata = '0;
    exp_nack = 1'b0;

    // m_done while idle is ignored
    bus.m_done = 1'b1;
    bus.m_rdata = 8'h3c;
    bus.m_ack_err = 1'b1;
    tick();
    bus.m_done = 1'b0;
    bus.m_ack_err = 1'b0;
    tick();
    check("idle_mdone_done", bus.done, 0);
    check("idle_mdone_rdata", bus.rdata, 0);
    check("idle_mdone_nack", bus.nack, 0);

    // Contention: all four held, order 0,1,2,3,0
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
    exp_q = '{0, 1, 2, 3, 0};
    while (exp_q.size() > 0) begin
      do_txn($urandom_range(0, 3), DATA_W'($urandom), 1'b0, 1'b0, w);
      check("rr_order", w, exp_q.pop_front());
    end
    bus.req = '0;

    // Write from requester 0
    set_req(0, 1'b0, 7'h50, 8'ha6);
    do_txn(2, 8'h11, 1'b0, 1'b0, w);
    bus.req = '0;

    // Read from requester 2, rdata held afterwards
    set_req(2, 1'b1, 7'h21, 8'h00);
    do_txn(1, 8'hf6, 1'b0, 1'b0, w);
    bus.req = '0;
    repeat (3) tick();
    check("rdata_held", bus.rdata, 8'hf6);

    // NACK, then a clean transaction clears it
    set_req(1, 1'b0, 7'h33, 8'h5a);
    do_txn(0, 8'h00, 1'b1, 1'b0, w);
    bus.req = '0;
    set_req(3, 1'b1, 7'h44, 8'h00);
    do_txn(3, 8'h9b, 1'b0, 1'b0, w);
    bus.req = '0;

    // m_busy blocks arbitration
    set_req(2, 1'b0, 7'h12, 8'h34);
    bus.m_busy = 1'b1;
    repeat (4) begin
      tick();
      check("busy_no_gnt", bus.gnt, 0);
      check("busy_no_start", bus.m_start, 0);
    end
    bus.m_busy = 1'b0;
    do_txn(1, 8'h00, 1'b0, 1'b1, w);
    bus.req = '0;

    // Reset in the middle of WAIT
    set_req(2, 1'b1, 7'h7f, 8'hff);
    tick();
    check("pre_rst_gnt", bus.gnt, onehot(pick(rr_last, 4'b0100)));
    bus.m_busy = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req = '0;
    bus.m_busy = 1'b0;
    rr_last = NREQ - 1;
    exp_rdata = '0;
    exp_nack = 1'b0;
    check_all_zero("mid_rst");
    bus.m_done = 1'b1;
    bus.m_rdata = 8'hee;
    tick();
    bus.m_done = 1'b0;
    repeat (2) begin
      tick();
      check("post_rst_no_done", bus.done, 0);
      check("post_rst_rdata", bus.rdata, 0);
    end
    set_req(0, 1'b0, 7'h01, 8'h02);
    set_req(1, 1'b1, 7'h03, 8'h00);
    do_txn(0, 8'h77, 1'b0, 1'b0, w);
    check("post_rst_winner", w, 0);
    bus.req[0] = 1'b0;
    do_txn(1, 8'h88, 1'b0, 1'b0, w);
    check("post_rst_second", w, 1);
    bus.req = '0;

    // Randomized traffic
    pending = '0;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      end
      if (bus.req == '0)
        set_req($urandom_range(0, NREQ - 1), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        bus.m_busy = 1'b1;
        repeat ($urandom_range(1, 3)) begin
          tick();
          check("rnd_busy_no_gnt", bus.gnt, 0);
        end
        bus.m_busy = 1'b0;
      end
      do_txn($urandom_range(0, 4), DATA_W'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), w);
      if (w >= 0) bus.req[w] = 1'b0;
      pending = bus.req;
    end
    bus.req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never completes: forced completion after TIMEOUT WAIT cycles
    begin
      int n;
      int tw;
      set_req(3, 1'b1, 7'h2a, 8'h00);
      tw = pick(rr_last, bus.req);
      tick();
      check("tmo_gnt", bus.gnt, onehot(tw));
      bus.m_busy = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.done == '0 && n < 40);
      check("tmo_latency", n, TIMEOUT + 1);
      check("tmo_done", bus.done, onehot(tw));
      check("tmo_nack", bus.nack, 1);
      check("tmo_flag", bus.tmo, 1);
      check("tmo_rdata", bus.rdata, exp_rdata);
      bus.req = '0;
      bus.m_done = 1'b1;
      bus.m_rdata = 8'h5a;
      bus.m_ack_err = 1'b0;
      tick();
      check("tmo_done_single", bus.done, 0);
      tick();
      bus.m_done = 1'b0;
      bus.m_busy = 1'b0;
      check("late_mdone_rdata", bus.rdata, exp_rdata);
      check("late_mdone_nack", bus.nack, 1);
      check("late_mdone_tmo", bus.tmo, 1);
      check("late_mdone_done", bus.done, 0);
      rr_last = tw;
      set_req(0, 1'b1, 7'h11, 8'h00);
      do_txn(1, 8'hc3, 1'b0, 1'b0, w);
      bus.req = '0;
    end
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
